pcie_fifo_unpack: RTL and testbench

//  Read-side companion of the 16b->128b PCIe prefetch FIFO path. Pops 128-bit words from a

---
 rtl/pcie_fifo_unpack.sv | 75 +++++++
 tb/tb_pcie_fifo_unpack.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_fifo_unpack.sv
// pcie_fifo_unpack: pops 128b words from a show-ahead FIFO and streams them out as 16b pixels with line markers.
// Optional PCIE_UNPACK_MSB_FIRST_EN selects MSB-first pixel order; the default build is LSB-first.
module pcie_fifo_unpack #(
    parameter int IN_W       = 128,
    parameter int OUT_W      = 16,
    parameter int RATIO      = 8,
    parameter int H_ACT      = 1280,
    parameter int LINE_CNT_W = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  fifo_rd_vld,
    input  logic [IN_W-1:0]       fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic [OUT_W-1:0]      pix_data,
    output logic                  pix_vld,
    input  logic                  pix_rdy,
    output logic                  pix_sol,
    output logic                  pix_eol,
    output logic [LINE_CNT_W-1:0] h_cnt,
    output logic                  underrun
);
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [IN_W-1:0]  word_q;
    logic             word_full;
    logic [IDX_W-1:0] idx;
    logic             acc;
    logic             last;
    logic             line_end;

    assign pix_vld    = word_full;
    assign acc        = word_full & pix_rdy;
    assign last       = acc & (idx == IDX_W'(RATIO - 1));
    assign line_end   = h_cnt == LINE_CNT_W'(H_ACT - 1);
    // Refill in the same cycle the final pixel leaves so word boundaries cost no bubble.
    assign fifo_rd_en = rst_n & fifo_rd_vld & ~flush & (~word_full | last);
    assign pix_sol    = word_full & (h_cnt == '0);
    assign pix_eol    = word_full & line_end;
`ifdef PCIE_UNPACK_MSB_FIRST_EN
    assign pix_data   = word_q[IN_W - 1 - int'(idx) * OUT_W -: OUT_W];
`else
    assign pix_data   = word_q[int'(idx) * OUT_W +: OUT_W];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q    <= '0;
            word_full <= 1'b0;
            idx       <= '0;
            h_cnt     <= '0;
            underrun  <= 1'b0;
        end else if (flush) begin
            word_full <= 1'b0;
            idx       <= '0;
            h_cnt     <= '0;
            underrun  <= 1'b0;
        end else begin
            if (fifo_rd_en) begin
                word_q    <= fifo_rd_data;
                word_full <= 1'b1;
                idx       <= '0;
            end else if (last) begin
                word_full <= 1'b0;
            end
            if (acc && !last)
                idx <= idx + 1'b1;
            if (acc)
                h_cnt <= line_end ? '0 : h_cnt + 1'b1;
            if (pix_rdy && !word_full && h_cnt != '0)
                underrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pcie_fifo_unpack.sv
// tb_pcie_fifo_unpack: directed bench for pcie_fifo_unpack with a queue-backed show-ahead FIFO and H_ACT=12.
// Build with PCIE_UNPACK_MSB_FIRST_EN to exercise MSB-first pixel order.
module tb_pcie_fifo_unpack;
    localparam int H = 12;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         fifo_rd_vld = 1'b0;
    logic [127:0] fifo_rd_data = '0;
    logic         fifo_rd_en;
    logic [15:0]  pix_data;
    logic         pix_vld;
    logic         pix_rdy = 1'b0;
    logic         pix_sol;
    logic         pix_eol;
    logic [3:0]   h_cnt;
    logic         underrun;

    logic [127:0] fq[$];
    logic [15:0]  exp_q[$];
    int total = 0;
    int bad = 0;
    int npop = 0;
    int hexp = 0;
    int widx = 0;

    pcie_fifo_unpack #(.IN_W(128), .OUT_W(16), .RATIO(8), .H_ACT(H), .LINE_CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .fifo_rd_vld(fifo_rd_vld),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .pix_data(pix_data),
        .pix_vld(pix_vld), .pix_rdy(pix_rdy), .pix_sol(pix_sol), .pix_eol(pix_eol),
        .h_cnt(h_cnt), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic upd();
        fifo_rd_vld  = fq.size() != 0;
        fifo_rd_data = fq.size() != 0 ? fq[0] : '0;
    endtask

    // FIFO model: the pop seen at the edge takes effect just after it.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            #1;
            void'(fq.pop_front());
            npop++;
            upd();
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_word(input int k);
        logic [127:0] w;
        for (int j = 0; j < 8; j++) w[16*j +: 16] = {k[7:0], j[7:0]};
        for (int j = 0; j < 8; j++)
`ifdef PCIE_UNPACK_MSB_FIRST_EN
            exp_q.push_back(w[127 - 16*j -: 16]);
`else
            exp_q.push_back(w[16*j +: 16]);
`endif
        fq.push_back(w);
        upd();
    endtask

    // Called on a negedge with pix_vld already high; ends on the negedge after the n-th acceptance.
    task automatic stream(input int n, input bit tog);
        int  acc_n = 0;
        int  c = 0;
        bit  r;
        while (acc_n < n && c < 200) begin
            r = tog ? (c % 2 == 0) : 1'b1;
            pix_rdy = r;
            #1;
            chk("vld", pix_vld, 1);
            chk("data", pix_data, exp_q.size() != 0 ? exp_q[0] : 16'hdead);
            chk("hcnt", h_cnt, hexp);
            chk("sol", pix_sol, hexp == 0);
            chk("eol", pix_eol, hexp == H - 1);
            chk("rden", fifo_rd_en, r && widx == 7 && fifo_rd_vld);
            if (r) begin
                void'(exp_q.pop_front());
                hexp = (hexp + 1) % H;
                widx = (widx + 1) % 8;
                acc_n++;
            end
            c++;
            step();
        end
        if (acc_n < n) chk("stream_timeout", acc_n, n);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        #1;
        chk("flush_rden", fifo_rd_en, 0);
        step();
        flush = 1'b0;
        if (pix_vld === 1'b0) begin
            hexp = 0;
            widx = 0;
        end
    endtask

    initial begin
        // reset state, with a word already waiting in the FIFO
        push_word(0);
        step();
        step();
        chk("rst_vld", pix_vld, 0);
        chk("rst_data", pix_data, 0);
        chk("rst_sol", pix_sol, 0);
        chk("rst_eol", pix_eol, 0);
        chk("rst_hcnt", h_cnt, 0);
        chk("rst_under", underrun, 0);
        chk("rst_rden", fifo_rd_en, 0);
        rst_n = 1'b1;
        #1;
        chk("t1_rden", fifo_rd_en, 1);
        step();
`ifdef PCIE_UNPACK_MSB_FIRST_EN
        chk("t1_first", pix_data, 16'h0007);
`else
        chk("t1_first", pix_data, 16'h0000);
`endif
        stream(8, 0);
        pix_rdy = 1'b0;
        #1;
        chk("t1_drain", pix_vld, 0);
        chk("t1_pops", npop, 1);
        chk("t1_under", underrun, 0);
        do_flush();
        chk("t1_fl_hcnt", h_cnt, 0);

        // four words back to back
        for (int k = 1; k <= 4; k++) push_word(k);
        step();
        stream(32, 0);
        pix_rdy = 1'b0;
        #1;
        chk("t2_drain", pix_vld, 0);
        chk("t2_pops", npop, 5);
        chk("t2_hcnt", h_cnt, 8);
        do_flush();

        // alternating ready
        push_word(5);
        push_word(6);
        step();
        stream(16, 1);
        pix_rdy = 1'b0;
        #1;
        chk("t3_drain", pix_vld, 0);
        chk("t3_pops", npop, 7);
        do_flush();

        // starvation inside a line
        push_word(7);
        step();
        stream(8, 0);
        step();
        chk("t5_under", underrun, 1);
        pix_rdy = 1'b0;
        step();
        step();
        chk("t5_sticky", underrun, 1);
        chk("t5_hcnt", h_cnt, 8);
        do_flush();
        chk("t5_fl_under", underrun, 0);
        chk("t5_fl_hcnt", h_cnt, 0);
        pix_rdy = 1'b1;
        step();
        chk("t5_sol_idle", underrun, 0);
        pix_rdy = 1'b0;

        // flush at idx 3 with the FIFO still holding a word
        push_word(8);
        push_word(9);
        step();
        stream(3, 0);
        pix_rdy = 1'b1;
        do_flush();
        for (int j = 0; j < 5; j++) void'(exp_q.pop_front());
        hexp = 0;
        widx = 0;
        chk("t6_vld", pix_vld, 0);
        chk("t6_pops", npop, 9);
        #1;
        chk("t6_rden", fifo_rd_en, 1);
        step();
        stream(8, 0);
        pix_rdy = 1'b0;
        chk("t6_pops2", npop, 10);

        // async reset mid-word discards the partial word
        push_word(10);
        step();
        stream(3, 0);
        pix_rdy = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("ar_vld", pix_vld, 0);
        chk("ar_hcnt", h_cnt, 0);
        step();
        rst_n = 1'b1;
        exp_q.delete();
        hexp = 0;
        widx = 0;
        push_word(11);
        step();
        stream(8, 0);
        pix_rdy = 1'b0;
        #1;
        chk("ar_drain", pix_vld, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
